sram_controller: RTL

Memory responder behind the MEM stage: accepts a 32-bit word read or write request (`MEMread`/`MEMwrite`, address, data) and serves it from an external 16-bit-wide asynchronous SRAM in two half-word phases. It asserts `ready` only when the access has completed, so the hazard/freeze logic stalls the whole pipeline while `ready` is low. It replaces the single-cycle `data_mem` as the backing store of the MEM stage.

---
 rtl/sram_controller_pkg.sv | 14 +
 rtl/sram_controller_if.sv | 21 ++
 rtl/register.sv | 18 +
 rtl/sram_controller_wait_counter.sv | 22 ++
 rtl/sram_controller.sv | 131 +++++++++++++
 5 files changed

// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the SRAM controller slice.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
    localparam int          DEF_SRAM_AW   = 18;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the controller: word request in, read word and ready out.
interface sram_controller_if;

    logic        MEMread;
    logic        MEMwrite;
    logic [31:0] address;
    logic [31:0] data;
    logic [31:0] MEM_result;
    logic        ready;

    modport master (
        output MEMread, MEMwrite, address, data,
        input  MEM_result, ready
    );

    modport slave (
        input  MEMread, MEMwrite, address, data,
        output MEM_result, ready
    );

endinterface

// File: rtl/register.sv
// Generic load-enable register with synchronous active-low clear.
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear on reset, otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (!rst)    q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/sram_controller_wait_counter.sv
// Phase cycle counter: counts 0..WAIT_CYCLES-1 and wraps on terminal count.
module wait_counter #(
    parameter int WAIT_CYCLES = 2,
    parameter int CW          = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = (count == CW'(WAIT_CYCLES - 1));

    // Clear takes priority; a terminal count wraps straight back to zero.
    always_ff @(posedge clk) begin
        if (!rst || clr) count <= '0;
        else if (en)     count <= tc ? '0 : count + CW'(1);
    end

endmodule

// File: rtl/sram_controller.sv
// 32-bit word access served from a 16-bit asynchronous SRAM in two half-word phases.
module sram_controller
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = 2,
    parameter int          SRAM_AW     = DEF_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_out,
    input  logic [15:0]        SRAM_DQ_in,
    output logic               SRAM_DQ_oe,
    output logic               SRAM_WE_N
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t             state, next_state;
    logic               req, start;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               tc, cnt_clr, cnt_en;
    logic               op_wr_q, op_wr;
    logic [SRAM_AW-2:0] word_live, word_q, word;
    logic [31:0]        data_q, cur_data;
    logic [15:0]        low_hold;
    logic               low_en, res_en;
    logic [SRAM_AW-1:0] addr_d;
    logic [15:0]        dq_d;
    logic               oe_d, we_n_d;

    assign req   = bus.MEMread | bus.MEMwrite;
    assign start = (state == IDLE) & req;

    // Word index of (address - BASE_ADDR); only bits [SRAM_AW:2] survive the
    // truncation, and with word-aligned operands no borrow crosses bit 2.
    assign word_live = bus.address[SRAM_AW:2] - BASE_ADDR[SRAM_AW:2];

    // Request fields captured on the IDLE->LOW edge; write wins over read.
    register #(.WIDTH(1))         u_op   (.clk, .rst, .en(start), .d(bus.MEMwrite), .q(op_wr_q));
    register #(.WIDTH(SRAM_AW-1)) u_word (.clk, .rst, .en(start), .d(word_live),    .q(word_q));
    register #(.WIDTH(32))        u_data (.clk, .rst, .en(start), .d(bus.data),     .q(data_q));

    // While still in IDLE the latches are not loaded yet, so the first phase
    // set-up must look at the live request.
    assign op_wr    = (state == IDLE) ? bus.MEMwrite : op_wr_q;
    assign word     = (state == IDLE) ? word_live    : word_q;
    assign cur_data = (state == IDLE) ? bus.data     : data_q;

    assign cnt_clr = (state == IDLE) | (state == DONE);
    assign cnt_en  = (state == LOW)  | (state == HIGH);

    wait_counter #(.WAIT_CYCLES(WAIT_CYCLES), .CW(CW)) u_cnt (
        .clk, .rst, .clr(cnt_clr), .en(cnt_en), .count(cnt), .tc(tc)
    );

    // Counter value the next cycle will see, used to pre-compute registered pins.
    assign cnt_nxt = (cnt_en && !tc) ? cnt + CW'(1) : '0;

    // Read path: low half held until the high half arrives.
    assign low_en = (state == LOW)  & tc & ~op_wr_q;
    assign res_en = (state == HIGH) & tc & ~op_wr_q;

    register #(.WIDTH(16)) u_low (.clk, .rst, .en(low_en), .d(SRAM_DQ_in), .q(low_hold));
    register #(.WIDTH(32)) u_res (.clk, .rst, .en(res_en), .d({SRAM_DQ_in, low_hold}),
                                  .q(bus.MEM_result));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state logic: each phase lasts until the counter's terminal count.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req) next_state = LOW;
            LOW:  if (tc)  next_state = HIGH;
            HIGH: if (tc)  next_state = DONE;
            DONE:          next_state = IDLE;
            default:       next_state = IDLE;
        endcase
    end

    // Output logic: ready, plus the SRAM pin values for the coming cycle.
    always_comb begin
        bus.ready = (state == DONE) | ((state == IDLE) & ~req);
        addr_d    = SRAM_ADDR;
        dq_d      = SRAM_DQ_out;
        oe_d      = 1'b0;
        we_n_d    = 1'b1;
        case (next_state)
            LOW: begin
                addr_d = {word, 1'b0};
                if (op_wr) begin
                    oe_d   = 1'b1;
                    dq_d   = cur_data[15:0];
                    we_n_d = (cnt_nxt == CW'(WAIT_CYCLES - 1));
                end
            end
            HIGH: begin
                addr_d = {word, 1'b1};
                if (op_wr) begin
                    oe_d   = 1'b1;
                    dq_d   = cur_data[31:16];
                    we_n_d = (cnt_nxt == CW'(WAIT_CYCLES - 1));
                end
            end
            default: ;
        endcase
    end

    // SRAM pins are registered so they only move at clock edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_WE_N   <= 1'b1;
        end else begin
            SRAM_ADDR   <= addr_d;
            SRAM_DQ_out <= dq_d;
            SRAM_DQ_oe  <= oe_d;
            SRAM_WE_N   <= we_n_d;
        end
    end

endmodule
